// File: rtl/rgb_fade_sequencer.sv
`default_nettype none
// ============================================================================
//  Module      : rgb_fade_sequencer
//  Description : Steps through a programmable palette of RGB colours and
//                ramps each PWM duty value 1 LSB per prescaled tick toward
//                the active entry, holds it, then advances (wrapping).
//  Ports       : clk, reset (async, active-high), enable, cfg_we/cfg_addr/
//                cfg_data (palette write port, data = {red,green,blue}),
//                red_val/green_val/blue_val (duty values), pwm_en,
//                step_idx, step_done (advance pulse), busy (FADE or HOLD)
//  Revision    : 1.0 - initial release
// ============================================================================
module rgb_fade_sequencer #(
    parameter int PWM_RESOLUTION_BITS = 8,
    parameter int NUM_STEPS           = 4,
    parameter int TICK_DIV            = 1000,
    parameter int HOLD_TICKS          = 256,
    localparam int AW                 = $clog2(NUM_STEPS)
) (
    input  logic                             clk,
    input  logic                             reset,
    input  logic                             enable,
    input  logic                             cfg_we,
    input  logic [AW-1:0]                    cfg_addr,
    input  logic [3*PWM_RESOLUTION_BITS-1:0] cfg_data,
    output logic [PWM_RESOLUTION_BITS-1:0]   red_val,
    output logic [PWM_RESOLUTION_BITS-1:0]   green_val,
    output logic [PWM_RESOLUTION_BITS-1:0]   blue_val,
    output logic                             pwm_en,
    output logic [AW-1:0]                    step_idx,
    output logic                             step_done,
    output logic                             busy
);

    localparam int c_W       = PWM_RESOLUTION_BITS;
    localparam int c_PRESC_W = $clog2(TICK_DIV);
    localparam int c_HOLD_W  = (HOLD_TICKS > 1) ? $clog2(HOLD_TICKS) : 1;

    localparam logic [1:0] c_ST_IDLE = 2'd0;
    localparam logic [1:0] c_ST_FADE = 2'd1;
    localparam logic [1:0] c_ST_HOLD = 2'd2;

    logic [1:0]           r_state,     w_state_nxt;
    logic [c_PRESC_W-1:0] r_presc,     w_presc_nxt;
    logic [c_HOLD_W-1:0]  r_hold_cnt,  w_hold_nxt;
    logic [c_W-1:0]       r_red,       w_red_nxt;
    logic [c_W-1:0]       r_green,     w_green_nxt;
    logic [c_W-1:0]       r_blue,      w_blue_nxt;
    logic [AW-1:0]        r_step_idx,  w_step_nxt;
    logic                 r_step_done, w_step_done_nxt;

    logic [3*c_W-1:0]     r_palette [NUM_STEPS];
    logic [3*c_W-1:0]     w_target;
    logic [c_W-1:0]       w_tgt_red, w_tgt_green, w_tgt_blue;
    logic                 w_tick;
    logic                 w_hold_last;
    logic                 w_all_eq;
    logic                 w_addr_ok;
    logic [AW-1:0]        w_step_inc;

    // Out-of-range palette addresses only exist when NUM_STEPS is not a
    // power of two.
    generate
        if (NUM_STEPS == (1 << AW)) begin : g_addr_full
            assign w_addr_ok = 1'b1;
        end else begin : g_addr_chk
            assign w_addr_ok = ({1'b0, cfg_addr} < (AW+1)'(NUM_STEPS));
        end
    endgenerate

    // Palette storage: writable in every state, cleared by reset.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < NUM_STEPS; i++) begin
                r_palette[i] <= '0;
            end
        end else if (cfg_we && w_addr_ok) begin
            r_palette[cfg_addr] <= cfg_data;
        end
    end

    assign w_target    = r_palette[r_step_idx];
    assign w_tgt_red   = w_target[3*c_W-1:2*c_W];
    assign w_tgt_green = w_target[2*c_W-1:c_W];
    assign w_tgt_blue  = w_target[c_W-1:0];

    assign w_tick      = (r_presc == c_PRESC_W'(TICK_DIV - 1));
    assign w_hold_last = (r_hold_cnt == c_HOLD_W'(HOLD_TICKS - 1));
    assign w_all_eq    = (r_red == w_tgt_red) && (r_green == w_tgt_green) &&
                         (r_blue == w_tgt_blue);
    assign w_step_inc  = (r_step_idx == AW'(NUM_STEPS - 1)) ? '0
                                                            : r_step_idx + AW'(1);

    // Move one LSB toward the target; equal channels stay put.
    function automatic logic [c_W-1:0] f_step(input logic [c_W-1:0] cur,
                                               input logic [c_W-1:0] tgt);
        if (cur < tgt) begin
            return cur + c_W'(1);
        end else if (cur > tgt) begin
            return cur - c_W'(1);
        end
        return cur;
    endfunction

    // Next-state and datapath logic.
    always_comb begin
        w_state_nxt     = r_state;
        w_presc_nxt     = r_presc;
        w_hold_nxt      = r_hold_cnt;
        w_red_nxt       = r_red;
        w_green_nxt     = r_green;
        w_blue_nxt      = r_blue;
        w_step_nxt      = r_step_idx;
        w_step_done_nxt = 1'b0;

        if (!enable) begin
            // Dropping enable wins over everything, including an advance
            // that would otherwise pulse step_done on this edge.
            w_state_nxt = c_ST_IDLE;
            w_presc_nxt = '0;
            w_hold_nxt  = '0;
            w_red_nxt   = '0;
            w_green_nxt = '0;
            w_blue_nxt  = '0;
            w_step_nxt  = '0;
        end else begin
            case (r_state)
                c_ST_IDLE: begin
                    w_state_nxt = c_ST_FADE;
                    w_presc_nxt = '0;
                    w_hold_nxt  = '0;
                end
                c_ST_FADE: begin
                    w_presc_nxt = w_tick ? '0 : r_presc + c_PRESC_W'(1);
                    if (w_all_eq) begin
                        w_state_nxt = c_ST_HOLD;
                        w_hold_nxt  = '0;
                    end else if (w_tick) begin
                        w_red_nxt   = f_step(r_red,   w_tgt_red);
                        w_green_nxt = f_step(r_green, w_tgt_green);
                        w_blue_nxt  = f_step(r_blue,  w_tgt_blue);
                    end
                end
                c_ST_HOLD: begin
                    // Targets are deliberately not re-checked while holding.
                    w_presc_nxt = w_tick ? '0 : r_presc + c_PRESC_W'(1);
                    if (w_tick) begin
                        if (w_hold_last) begin
                            w_hold_nxt      = '0;
                            w_step_nxt      = w_step_inc;
                            w_step_done_nxt = 1'b1;
                            w_state_nxt     = c_ST_FADE;
                        end else begin
                            w_hold_nxt = r_hold_cnt + c_HOLD_W'(1);
                        end
                    end
                end
                default: begin
                    w_state_nxt = c_ST_IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state     <= c_ST_IDLE;
            r_presc     <= '0;
            r_hold_cnt  <= '0;
            r_red       <= '0;
            r_green     <= '0;
            r_blue      <= '0;
            r_step_idx  <= '0;
            r_step_done <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_presc     <= w_presc_nxt;
            r_hold_cnt  <= w_hold_nxt;
            r_red       <= w_red_nxt;
            r_green     <= w_green_nxt;
            r_blue      <= w_blue_nxt;
            r_step_idx  <= w_step_nxt;
            r_step_done <= w_step_done_nxt;
        end
    end

    // pwm_en and busy come straight from the state register.
    assign red_val   = r_red;
    assign green_val = r_green;
    assign blue_val  = r_blue;
    assign step_idx  = r_step_idx;
    assign step_done = r_step_done;
    assign pwm_en    = (r_state != c_ST_IDLE);
    assign busy      = (r_state == c_ST_FADE) || (r_state == c_ST_HOLD);

endmodule
`default_nettype wire

// File: tb/tb_rgb_fade_sequencer.sv
`default_nettype none
// ============================================================================
//  Module      : tb_rgb_fade_sequencer
//  Description : Self-checking bench for rgb_fade_sequencer with
//                TICK_DIV=4, HOLD_TICKS=3, NUM_STEPS=4, 8-bit duty values.
//                Each advance costs: fade ticks*4 cycles, +1 equal-check
//                cycle, then 3 hold ticks aligned to the free-running
//                prescaler.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_rgb_fade_sequencer;

    localparam int c_W  = 8;
    localparam int c_NS = 4;
    localparam int c_AW = 2;

    logic              clk;
    logic              reset;
    logic              enable;
    logic              cfg_we;
    logic [c_AW-1:0]   cfg_addr;
    logic [3*c_W-1:0]  cfg_data;
    logic [c_W-1:0]    red_val;
    logic [c_W-1:0]    green_val;
    logic [c_W-1:0]    blue_val;
    logic              pwm_en;
    logic [c_AW-1:0]   step_idx;
    logic              step_done;
    logic              busy;

    rgb_fade_sequencer #(
        .PWM_RESOLUTION_BITS (c_W),
        .NUM_STEPS           (c_NS),
        .TICK_DIV            (4),
        .HOLD_TICKS          (3)
    ) u_dut (
        .clk       (clk),
        .reset     (reset),
        .enable    (enable),
        .cfg_we    (cfg_we),
        .cfg_addr  (cfg_addr),
        .cfg_data  (cfg_data),
        .red_val   (red_val),
        .green_val (green_val),
        .blue_val  (blue_val),
        .pwm_en    (pwm_en),
        .step_idx  (step_idx),
        .step_done (step_done),
        .busy      (busy)
    );

    typedef struct {
        int       cyc;
        int       idx;
        int       r;
        int       g;
        int       b;
    } exp_t;

    exp_t q[$];
    exp_t r_e;
    int   cyc    = 0;
    int   n_tests = 0;
    int   n_fail  = 0;
    int   e0;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input int act, input int exp);
        n_tests++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Scoreboard monitor: every step_done pulse must match the queue head.
    always @(negedge clk) begin
        if (!reset && step_done) begin
            if (q.size() == 0) begin
                n_tests++;
                n_fail++;
                $display("FAIL unexpected_step_done: got pulse with step_idx=%0d at cycle %0d, expected none",
                         step_idx, cyc);
            end else begin
                r_e = q.pop_front();
                check("sd_cycle", cyc, r_e.cyc);
                check("sd_idx",   int'(step_idx),  r_e.idx);
                check("sd_red",   int'(red_val),   r_e.r);
                check("sd_green", int'(green_val), r_e.g);
                check("sd_blue",  int'(blue_val),  r_e.b);
            end
        end
    end

    // Advance to #1 after posedge number t.
    task automatic go_to(input int t);
        while (cyc < t) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic write_pal(input logic [1:0] a, input logic [7:0] r,
                             input logic [7:0] g, input logic [7:0] b);
        cfg_we   = 1'b1;
        cfg_addr = a;
        cfg_data = {r, g, b};
        @(posedge clk);
        #1;
        cfg_we   = 1'b0;
    endtask

    task automatic do_reset();
        reset  = 1'b1;
        enable = 1'b0;
        cfg_we = 1'b0;
        @(posedge clk);
        @(posedge clk);
        #1;
        reset = 1'b0;
    endtask

    task automatic push_exp(input int c, input int i, input int r, input int g, input int b);
        exp_t e;
        e.cyc = c; e.idx = i; e.r = r; e.g = g; e.b = b;
        q.push_back(e);
    endtask

    // Enable is sampled on the following edge, E0.
    task automatic start();
        enable = 1'b1;
        e0 = cyc + 1;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation still running at cycle %0d, expected completion", cyc);
        $fatal(1, "watchdog expired");
    end

    initial begin
        reset    = 1'b1;
        enable   = 1'b0;
        cfg_we   = 1'b0;
        cfg_addr = '0;
        cfg_data = '0;
        #2;
        check("rst_pwm_en", int'(pwm_en), 0);
        check("rst_busy",   int'(busy),   0);
        @(posedge clk);
        @(posedge clk);
        #1;
        reset = 1'b0;

        // ---- reset / idle: enable low for 100 cycles ----
        go_to(cyc + 100);
        check("idle_red",   int'(red_val),   0);
        check("idle_green", int'(green_val), 0);
        check("idle_blue",  int'(blue_val),  0);
        check("idle_pwm",   int'(pwm_en),    0);
        check("idle_busy",  int'(busy),      0);
        check("idle_idx",   int'(step_idx),  0);
        check("idle_done",  int'(step_done), 0);

        // ---- basic fade toward {8,0,4} ----
        write_pal(2'd0, 8'd8, 8'd0, 8'd4);
        start();
        push_exp(e0 + 44, 1, 8, 0, 4);
        go_to(e0);
        check("bf_busy",   int'(busy),   1);
        check("bf_pwm",    int'(pwm_en), 1);
        check("bf_red0",   int'(red_val), 0);
        go_to(e0 + 4);
        check("bf_red1",   int'(red_val), 1);
        go_to(e0 + 16);
        check("bf_blue4",  int'(blue_val), 4);
        check("bf_red4",   int'(red_val),  4);
        check("bf_green",  int'(green_val), 0);
        go_to(e0 + 32);
        check("bf_red8",   int'(red_val), 8);
        go_to(e0 + 43);
        check("bf_idx_hold", int'(step_idx), 0);
        go_to(e0 + 46);
        check("bf_idx_after", int'(step_idx), 1);
        do_reset();

        // ---- wrap-around across the four entries ----
        write_pal(2'd0, 8'd10, 8'd0,  8'd0);
        write_pal(2'd1, 8'd0,  8'd10, 8'd0);
        write_pal(2'd2, 8'd0,  8'd0,  8'd10);
        write_pal(2'd3, 8'd10, 8'd10, 8'd10);
        start();
        push_exp(e0 + 52,  1, 10, 0,  0);
        push_exp(e0 + 104, 2, 0,  10, 0);
        push_exp(e0 + 156, 3, 0,  0,  10);
        push_exp(e0 + 208, 0, 10, 10, 10);
        push_exp(e0 + 260, 1, 10, 0,  0);
        go_to(e0 + 262);
        do_reset();

        // ---- retarget mid-fade: 200 -> 50 when red is 120 ----
        write_pal(2'd0, 8'd200, 8'd0, 8'd0);
        start();
        go_to(e0 + 480);
        check("rt_red120", int'(red_val), 120);
        write_pal(2'd0, 8'd50, 8'd0, 8'd0);
        push_exp(e0 + 772, 1, 50, 0, 0);
        go_to(e0 + 484);
        check("rt_red119", int'(red_val), 119);
        go_to(e0 + 500);
        check("rt_red115", int'(red_val), 115);
        go_to(e0 + 760);
        check("rt_red50",  int'(red_val), 50);
        go_to(e0 + 770);
        check("rt_no_overshoot", int'(red_val), 50);
        go_to(e0 + 774);
        do_reset();

        // ---- enable drop mid-HOLD, then re-enable ----
        write_pal(2'd0, 8'd8, 8'd0, 8'd4);
        start();
        go_to(e0 + 38);
        check("ed_red_hold", int'(red_val), 8);
        enable = 1'b0;
        go_to(e0 + 39);
        check("ed_red",  int'(red_val),  0);
        check("ed_blue", int'(blue_val), 0);
        check("ed_idx",  int'(step_idx), 0);
        check("ed_pwm",  int'(pwm_en),   0);
        check("ed_busy", int'(busy),     0);
        go_to(e0 + 50);
        start();
        push_exp(e0 + 44, 1, 8, 0, 4);
        go_to(e0 + 4);
        check("ed_re_red",  int'(red_val),  1);
        check("ed_re_blue", int'(blue_val), 1);
        go_to(e0 + 46);
        enable = 1'b0;

        // ---- async reset mid-fade at red = 37 ----
        write_pal(2'd0, 8'd200, 8'd0, 8'd0);
        go_to(cyc + 2);
        start();
        go_to(e0 + 149);
        check("ar_red37", int'(red_val), 37);
        #3;
        reset = 1'b1;
        #1;
        check("ar_red0",  int'(red_val), 0);
        check("ar_pwm0",  int'(pwm_en),  0);
        check("ar_busy0", int'(busy),    0);
        enable = 1'b0;
        @(posedge clk);
        @(posedge clk);
        #1;
        reset = 1'b0;
        go_to(cyc + 1);
        start();
        push_exp(e0 + 12, 1, 0, 0, 0);
        go_to(e0 + 1);
        check("ar_busy_hold", int'(busy),    1);
        check("ar_red_zero",  int'(red_val), 0);
        go_to(e0 + 14);
        enable = 1'b0;

        go_to(cyc + 5);
        check("sb_drain", q.size(), 0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
